// File: rtl/switch_press_pkg.sv
// Shared types for the switch press classifier.
package switch_press_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      HELD    = 2'd2
   } press_state_t;

endpackage

// File: rtl/switch_press_decoder.sv
// Classifies debounced presses as short/long; one-cycle event pulses, held flag, toggling LED.
// All outputs registered one edge after the deciding sample; no input backpressure.
module switch_press_decoder
   import switch_press_pkg::*;
#(
   parameter int LONG_PRESS_LIMIT = 250000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_switch,
   output logic o_short_press,
   output logic o_long_press,
   output logic o_release,
   output logic o_held,
   output logic o_led
);

   localparam int CW = $clog2(LONG_PRESS_LIMIT);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(LONG_PRESS_LIMIT - 1);

   press_state_t   state;
   logic [CW-1:0]  cnt;
   logic           long_hit;
   logic           short_hit;
   logic           release_hit;

   // Decisions shared by the state and output registers so both agree on the same edge.
   assign long_hit    = (state == PRESSED) && i_switch && (cnt == CNT_LAST);
   assign short_hit   = (state == PRESSED) && !i_switch;
   assign release_hit = (state != IDLE) && !i_switch;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (i_switch) begin
                  state <= PRESSED;
                  cnt   <= CNT_ONE;
               end
            end
            PRESSED: begin
               if (!i_switch) begin
                  state <= IDLE;
               end else if (long_hit) begin
                  state <= HELD;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            HELD: begin
               if (!i_switch) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_short_press <= 1'b0;
         o_long_press  <= 1'b0;
         o_release     <= 1'b0;
         o_held        <= 1'b0;
         o_led         <= 1'b0;
      end else begin
         o_short_press <= short_hit;
         o_long_press  <= long_hit;
         o_release     <= release_hit;
         o_held        <= long_hit || ((state == HELD) && i_switch);
         if (short_hit) begin
            o_led <= ~o_led;
         end
      end
   end

endmodule
